seq_shift_unit: RTL

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/seq_shift_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter (LSL, LSR, ASR, ROL) that moves up to
// STEP bit positions per clock and reports bits lost off the register ends.
//
// Handshake: start is a request sampled only while idle; it has no ready
// return, so a request made while busy or while done is high is dropped.
// done is a one-cycle pulse. out/overflow change only on the edge that
// raises done and then hold until the next done.
module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Counter wide enough to hold the value WIDTH itself (saturated amount).
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
  localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONES    = '1;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    n_start;
  logic [WIDTH-1:0] b_mod;
  logic [CW-1:0]    step_amt;
  logic [WIDTH-1:0] shl_v, shr_v, sar_v, rol_v;
  logic [WIDTH-1:0] lost_hi, lost_lo;
  logic [WIDTH-1:0] step_res;
  logic             step_lost;

  // Effective amount: rotation wraps modulo WIDTH, other modes saturate at WIDTH.
  always_comb begin
    b_mod = B % WIDTH_W;
    if (op == OP_ROL) begin
      n_start = CW'(b_mod);
    end else if (B >= WIDTH_W) begin
      n_start = WIDTH_C;
    end else begin
      n_start = CW'(B);
    end
  end

  // One shift step of min(STEP, remaining) positions plus the bits it drops.
  always_comb begin
    step_amt  = (rem_q > STEP_C) ? STEP_C : rem_q;
    shl_v     = work_q << step_amt;
    shr_v     = work_q >> step_amt;
    sar_v     = $signed(work_q) >>> step_amt;
    // ROL amounts stay below WIDTH, so the right-shift term never sees 0.
    rol_v     = shl_v | (work_q >> (WIDTH_C - step_amt));
    lost_hi   = work_q & ~(ONES >> step_amt);
    lost_lo   = work_q & ~(ONES << step_amt);
    step_res  = work_q;
    step_lost = 1'b0;
    case (op_q)
      OP_LSL: begin
        step_res  = shl_v;
        step_lost = |lost_hi;
      end
      OP_LSR: begin
        step_res  = shr_v;
        step_lost = |lost_lo;
      end
      OP_ASR: begin
        // The MSB of the working register always equals the latched sign.
        step_res  = sar_v;
        step_lost = |lost_lo;
      end
      default: begin
        step_res  = rol_v;
        step_lost = 1'b0;
      end
    endcase
  end

  // Next-state and datapath control for IDLE -> SHIFT -> DONE -> IDLE.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    op_d       = op_q;
    ovf_d      = ovf_q;
    out_d      = out_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = A;
          op_d    = op;
          ovf_d   = 1'b0;
          rem_d   = n_start;
          state_d = (n_start != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        work_d = step_res;
        ovf_d  = ovf_q | step_lost;
        rem_d  = rem_q - step_amt;
        if (rem_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Result is published on the edge that raises done, so it is valid with it.
    if (state_d == S_DONE) begin
      out_d      = work_d;
      overflow_d = ovf_d;
    end
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      op_q       <= OP_LSL;
      ovf_q      <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      ovf_q      <= ovf_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule
